jtframe_sdram_arb: RTL and testbench
====================================

# jtframe_sdram_arb

Shares the single game-side SDRAM read port (sdram_req/sdram_ack/sdram_addr/data_read/data_rdy) among SLOTS ROM requesters. Each slot keeps a one-entry cache (last address and data) so repeated reads hit without SDRAM traffic. Misses are granted round-robin, with one transaction outstanding at a time. The block sits between the game's ROM clients and the board SDRAM controller, and it drives refresh_en whenever the port is idle.

## Interface
- SLOTS, 4: number of requesters (2..8)
- AW, 22: SDRAM word address width
- DW, 32: read data width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- downloading  in  1  ROM load in progress; blocks grants and flushes caches
- slot_cs  in  SLOTS  per-slot read request, level
- slot_addr  in  SLOTS*AW  per-slot address, slot i at [i*AW +: AW]
- slot_ok  out  SLOTS  slot i data valid for current slot_addr
- slot_dout  out  SLOTS*DW  per-slot cached data
- sdram_req  out  1  request to controller, held until ack
- sdram_addr  out  AW  latched address of granted slot
- sdram_ack  in  1  one-cycle pulse: request accepted
- data_read  in  DW  read data, valid when data_rdy
- data_rdy  in  1  one-cycle pulse: data_read valid
- refresh_en  out  1  controller may refresh now

## Operation
- Per slot: valid bit, cache_addr[AW], cache_data[DW].
- hit[i] = slot_cs[i] & valid[i] & (slot_addr[i]==cache_addr[i]); slot_ok[i] = hit[i] (combinational from registers); slot_dout[i] = cache_data[i] always.
- pend[i] = slot_cs[i] & ~hit[i].
- State machine: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE: when downloading=0 and any pend, grant the first pending slot at or after rr (wrapping modulo SLOTS). Latch sel and sdram_addr <= slot_addr[sel], set sdram_req=1, set rr <= sel+1 (wrapping), and go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack, clear sdram_req and go to WAIT_DATA. If data_rdy arrives in the same cycle as the ack, complete immediately and go to IDLE.
- WAIT_DATA: on data_rdy, write cache_data[sel]<=data_read, cache_addr[sel]<=sdram_addr, and valid[sel]<=1 (unless downloading), then go to IDLE.
- If slot_cs drops or slot_addr changes mid-transaction, the transaction still completes and fills the cache with the latched address. A changed address then misses and is re-requested.
- downloading=1 clears all valid bits every cycle and prevents new grants. An in-flight transaction runs to completion, but its fill is discarded (valid stays 0).
- refresh_en = (state==IDLE) & ~|pend, or downloading.
- data_rdy outside WAIT_ACK/WAIT_DATA is ignored.
- Reset values: state IDLE, rr 0, all valid 0, cache_addr 0, cache_data 0, sdram_req 0, sdram_addr 0, slot_ok 0, refresh_en 1.

## Timing
- Hit latency is 0 cycles: slot_ok rises in the same cycle slot_cs/slot_addr match.
- Miss: the pend seen at edge E0 gives sdram_req=1 after E0. An ack sampled at edge Ea gives req=0 after Ea. data_rdy sampled at Ed gives slot_ok=1 after Ed.
- Minimum miss latency is 2 edges (ack and data_rdy together at E1). It is 3 edges with separate pulses.
- Back-to-back: the next grant is issued at the edge after the fill, with one IDLE cycle between transactions.
- Fairness: a pending slot waits at most SLOTS-1 other transactions.

## Structure
- Package jtframe_sdram_arb_pkg holds the state enum (IDLE, WAIT_ACK, WAIT_DATA), the localparam for the SEL width ($clog2(SLOTS)), and the round-robin pick function.
- Sub-module jtframe_sdram_arb_slot holds one slot's valid, cache_addr and cache_data registers, the hit compare, and the fill/flush inputs. It is instantiated SLOTS times in a generate loop.

## Test plan
- Single miss then hit: slot0 cs at addr 0x00100; controller acks after 2 cycles and sends data_rdy with 0xDEADBEEF after 4 more. Required: slot_ok[0]=1 one cycle after data_rdy with dout 0xDEADBEEF. A re-read at 0x00100 stays ok with no new sdram_req.
- Round-robin: all 4 slots miss simultaneously. Required: grants in order 0,1,2,3. A new slot0 miss while slot2 is being served is granted after slot3.
- Address change mid-flight: slot1 at 0x200 is granted, then its addr changes to 0x300 before data_rdy. Required: the fill is stored with 0x200, slot_ok[1]=0, and a new request for 0x300 follows.
- Simultaneous ack+data_rdy: both are pulsed in the first WAIT_ACK cycle. Required: the fill completes, state returns to IDLE, and sdram_req falls.
- Download flush: with caches valid, raise downloading mid-transaction. Required: all slot_ok=0, no new sdram_req, the in-flight fill is discarded, and refresh_en=1.
- Async reset mid-WAIT_DATA: assert rst. Required: sdram_req=0, slot_ok all 0 and refresh_en=1 immediately without a clock edge, and a later data_rdy is ignored.

Source files
------------

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM read-port arbiter: FSM states,
// slot-select width and the round-robin pick.
package jtframe_sdram_arb_pkg;

  localparam int MAX_SLOTS = 8;
  localparam int SEL_W     = $clog2(MAX_SLOTS);

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // First pending slot at or after rr, wrapping at slots.
  function automatic sel_t rr_pick(input logic [MAX_SLOTS-1:0] pend,
                                   input sel_t rr,
                                   input int unsigned slots);
    sel_t        pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_SLOTS; k++) begin
      if (k < slots) begin
        idx = 32'(rr) + k;
        if (idx >= slots) idx = idx - slots;
        if (!found && pend[idx[SEL_W-1:0]]) begin
          found = 1'b1;
          pick  = idx[SEL_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/jtframe_sdram_arb_slot.sv
// One requester's single-entry read cache: valid bit, tag and data, with
// a combinational hit compare against the live request address.
module jtframe_sdram_arb_slot #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          hit,
  output logic [DW-1:0] dout
);

  logic          valid;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
    end else begin
      // Flush wins so a fill can never revalidate during a ROM download.
      if (flush)     valid <= 1'b0;
      else if (fill) valid <= 1'b1;
      if (fill) begin
        cache_addr <= fill_addr;
        cache_data <= fill_data;
      end
    end
  end

  assign hit  = cs & valid & (addr == cache_addr);
  assign dout = cache_data;

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS cached ROM
// requesters, one transaction in flight at a time.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy,
  output logic                refresh_en,
  output state_t              state_dbg
);

  // Handshake: sdram_req rises with sdram_addr stable and both hold until the
  // single-cycle sdram_ack; data_rdy is a single-cycle pulse, honoured only
  // while a transaction is outstanding (WAIT_ACK with ack, or WAIT_DATA).

  state_t               state;
  sel_t                 sel, rr, pick;
  logic [SLOTS-1:0]     hit, pend;
  logic [MAX_SLOTS-1:0] pend_x;
  logic                 complete, fill;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtframe_sdram_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .cs        (slot_cs[i]),
      .addr      (slot_addr[i*AW +: AW]),
      .flush     (downloading),
      .fill      (fill && (sel == sel_t'(i))),
      .fill_addr (sdram_addr),
      .fill_data (data_read),
      .hit       (hit[i]),
      .dout      (slot_dout[i*DW +: DW])
    );
  end

  assign pend    = slot_cs & ~hit;
  assign slot_ok = hit;

  always_comb begin
    pend_x = '0;
    for (int i = 0; i < SLOTS; i++) pend_x[i] = pend[i];
    pick = rr_pick(pend_x, rr, SLOTS);
  end

  assign complete   = (state == WAIT_ACK && sdram_ack && data_rdy) ||
                      (state == WAIT_DATA && data_rdy);
  assign fill       = complete && !downloading;
  assign refresh_en = (state == IDLE && !(|pend)) || downloading;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      rr         <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!downloading && |pend) begin
            sel        <= pick;
            sdram_addr <= slot_addr[int'(pick)*AW +: AW];
            sdram_req  <= 1'b1;
            rr         <= (pick == sel_t'(SLOTS-1)) ? '0 : pick + sel_t'(1);
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= data_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: a bench-driven SDRAM controller with
// hand-computed expected grants, cache contents and handshake levels.
module tb_jtframe_sdram_arb;
  import jtframe_sdram_arb_pkg::*;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk, rst, downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req, sdram_ack, data_rdy, refresh_en;
  logic [AW-1:0]       sdram_addr;
  logic [DW-1:0]       data_read;
  state_t              state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_read   (data_read),
    .data_rdy    (data_rdy),
    .refresh_en  (refresh_en),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] dout_of(input int i);
    return slot_dout[i*DW +: DW];
  endfunction

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!sdram_req && n < 50) begin
      step();
      n++;
    end
    check(tag, sdram_req, 1);
  endtask

  // Controller model: ack after ad idle cycles, data dd cycles after the ack (0 = same cycle).
  task automatic serve(input int ad, input int dd, input logic [DW-1:0] d);
    repeat (ad) step();
    sdram_ack = 1'b1;
    if (dd == 0) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    step();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (dd > 0) begin
      repeat (dd - 1) step();
      data_rdy  = 1'b1;
      data_read = d;
      step();
      data_rdy  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    slot_cs     = '0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    downloading = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    step(); step();
    check("rst_req", sdram_req, 0);
    check("rst_ok", slot_ok, 4'h0);
    check("rst_refresh", refresh_en, 1);
    check("rst_state", state_dbg, IDLE);
    check("rst_addr", sdram_addr, 0);
    rst = 1'b0;

    // Single miss then hit
    set_addr(0, 22'h00100);
    slot_cs = 4'b0001;
    #1;
    check("t1_refresh_pend", refresh_en, 0);
    check("t1_ok_before", slot_ok, 4'h0);
    step();
    check("t1_req", sdram_req, 1);
    check("t1_addr", sdram_addr, 22'h00100);
    check("t1_state_ack", state_dbg, WAIT_ACK);
    step(); step();
    check("t1_req_held", sdram_req, 1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("t1_req_drop", sdram_req, 0);
    check("t1_state_data", state_dbg, WAIT_DATA);
    repeat (3) step();
    check("t1_ok_waiting", slot_ok, 4'h0);
    data_rdy = 1'b1; data_read = 32'hDEADBEEF;
    step();
    data_rdy = 1'b0;
    check("t1_ok_after", slot_ok, 4'b0001);
    check("t1_dout", dout_of(0), 32'hDEADBEEF);
    check("t1_refresh_idle", refresh_en, 1);
    repeat (3) step();
    check("t1_reread_noreq", sdram_req, 0);
    check("t1_reread_ok", slot_ok, 4'b0001);

    // Round-robin from rr=0
    do_reset();
    for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h01000 + 22'(i * 16));
    slot_cs = 4'hF;
    step();
    check("rr_g0", sdram_addr, 22'h01000);
    serve(0, 1, 32'h11110000);
    wait_req("rr_req1");
    check("rr_g1", sdram_addr, 22'h01010);
    serve(1, 2, 32'h11110001);
    wait_req("rr_req2");
    check("rr_g2", sdram_addr, 22'h01020);
    set_addr(0, 22'h02000);
    serve(0, 1, 32'h11110002);
    wait_req("rr_req3");
    check("rr_g3", sdram_addr, 22'h01030);
    serve(0, 0, 32'h11110003);
    wait_req("rr_req4");
    check("rr_g4_slot0", sdram_addr, 22'h02000);
    serve(0, 1, 32'h22220000);
    check("rr_ok_all", slot_ok, 4'hF);
    check("rr_dout0", dout_of(0), 32'h22220000);
    check("rr_dout1", dout_of(1), 32'h11110001);
    check("rr_dout2", dout_of(2), 32'h11110002);
    check("rr_dout3", dout_of(3), 32'h11110003);
    step(); step();
    check("rr_idle_noreq", sdram_req, 0);

    // Address change mid-flight on slot1 (rr now 1)
    set_addr(1, 22'h00200);
    wait_req("mf_req");
    check("mf_addr", sdram_addr, 22'h00200);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    set_addr(1, 22'h00300);
    step();
    data_rdy = 1'b1; data_read = 32'hCAFE0200;
    step();
    data_rdy = 1'b0;
    check("mf_ok_miss", slot_ok[1], 0);
    check("mf_dout", dout_of(1), 32'hCAFE0200);
    set_addr(1, 22'h00200);
    #1;
    check("mf_tag_0x200_hit", slot_ok[1], 1);
    set_addr(1, 22'h00300);
    #1;
    wait_req("mf_rereq");
    check("mf_rereq_addr", sdram_addr, 22'h00300);

    // Simultaneous ack + data_rdy in the first WAIT_ACK cycle
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hCAFE0300;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    check("sim_state", state_dbg, IDLE);
    check("sim_req", sdram_req, 0);
    check("sim_ok", slot_ok[1], 1);
    check("sim_dout", dout_of(1), 32'hCAFE0300);

    // Download flush mid-transaction (rr now 2)
    set_addr(2, 22'h00400);
    wait_req("dl_req");
    check("dl_addr", sdram_addr, 22'h00400);
    downloading = 1'b1;
    #1;
    check("dl_refresh", refresh_en, 1);
    step();
    check("dl_ok_flushed", slot_ok, 4'h0);
    check("dl_req_inflight", sdram_req, 1);
    serve(0, 2, 32'hBAD0BAD0);
    check("dl_state", state_dbg, IDLE);
    check("dl_fill_discarded", slot_ok, 4'h0);
    repeat (3) step();
    check("dl_no_grant", sdram_req, 0);
    check("dl_refresh_hold", refresh_en, 1);
    downloading = 1'b0;
    step();
    check("dl_resume_req", sdram_req, 1);
    check("dl_resume_addr", sdram_addr, 22'h01030);

    // Async reset while waiting for data
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("ar_state_data", state_dbg, WAIT_DATA);
    rst = 1'b1;
    slot_cs = '0;
    #1;
    check("ar_req", sdram_req, 0);
    check("ar_ok", slot_ok, 4'h0);
    check("ar_refresh", refresh_en, 1);
    check("ar_state", state_dbg, IDLE);
    step();
    rst = 1'b0;
    data_rdy = 1'b1; data_read = 32'h5A5A5A5A;
    step();
    data_rdy = 1'b0;
    check("ar_rdy_ignored_state", state_dbg, IDLE);
    check("ar_rdy_ignored_req", sdram_req, 0);
    slot_cs = 4'b1000;
    #1;
    check("ar_no_fill", slot_ok, 4'h0);
    step();
    check("ar_regrant", sdram_req, 1);
    check("ar_regrant_addr", sdram_addr, 22'h01030);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
